// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch/PC datapath stage.
//   - PCSrc encodings used by the control FSM
//   - Opcode and jump-target field positions within the instruction word
//   - Branch-tracker phase encodings
package fetch_pc_unit_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   // Next-PC select encodings
   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_INC = 2'b01;
   localparam logic [1:0] PCSRC_REG = 2'b10;
   localparam logic [1:0] PCSRC_TGT = 2'b11;

   // Instruction field positions
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned JTGT_W  = 12;  // pseudo-direct jump field IR[11:0]

   // Branch tracker phases
   localparam logic [0:0] BR_IDLE = 1'b0;
   localparam logic [0:0] BR_EVAL = 1'b1;

endpackage

// File: rtl/fetch_pc_unit_branch_resolver.sv
// Two-phase BEQ tracker.
// The first Branch cycle captures the ALU zero flag; the second Branch cycle
// decides whether the PC is redirected. Dropping Branch between the two
// cycles aborts the pair.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   branch_i        Branch qualifier from the control FSM
//   zero_i          combinational ALU zero flag
//   take_branch_o   combinational: redirect PC on this edge
//   branch_taken_o  registered one-cycle pulse after a taken branch
module fetch_pc_unit_branch_resolver
   import fetch_pc_unit_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic branch_i,
   input  logic zero_i,
   output logic take_branch_o,
   output logic branch_taken_o
);

   logic [0:0] br_phase_q;
   logic       zero_q;
   logic       br_taken_q;

   assign take_branch_o  = (br_phase_q == BR_EVAL) && branch_i && zero_q;
   assign branch_taken_o = br_taken_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         br_phase_q <= BR_IDLE;
         zero_q     <= 1'b0;
         br_taken_q <= 1'b0;
      end else begin
         br_taken_q <= take_branch_o;
         case (br_phase_q)
            BR_IDLE: begin
               if (branch_i) begin
                  zero_q     <= zero_i;
                  br_phase_q <= BR_EVAL;
               end
            end
            // Both resolve and abort end the pair
            default: br_phase_q <= BR_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC datapath stage: owns the program counter and instruction register.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   PCSrc        next-PC select (ALU / PC+1 / RegA / target)
//   PCWrite      unconditional PC load enable (ignored while Branch=1)
//   Branch       conditional-branch qualifier, two-cycle BEQ protocol
//   IRWrite      IR load enable
//   MemData      instruction word from memory
//   ALUOut       ALU result register
//   RegA         jump-register source
//   Zero         ALU zero flag
//   PC, IR       current PC and instruction
//   Opcode       IR[15:12]
//   LinkAddr     pre-update PC for JAL link write
//   BranchTaken  one-cycle pulse after a taken BEQ
//   NextPC       selected next-PC value
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned        DATA_W   = DATA_W_DEF,
   parameter logic [DATA_W-1:0]  RESET_PC = '0,
   parameter int unsigned        OFF_W    = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [1:0]        PCSrc,
   input  logic              PCWrite,
   input  logic              Branch,
   input  logic              IRWrite,
   input  logic [DATA_W-1:0] MemData,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] RegA,
   input  logic              Zero,
   output logic [DATA_W-1:0] PC,
   output logic [DATA_W-1:0] IR,
   output logic [OPC_W-1:0]  Opcode,
   output logic [DATA_W-1:0] LinkAddr,
   output logic              BranchTaken,
   output logic [DATA_W-1:0] NextPC
);

   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] target;
   logic [DATA_W-1:0] br_off;
   logic              take_branch;

   // Sign-extended branch offset; PC already points past the branch
   assign br_off = {{(DATA_W - OFF_W){ir_q[OFF_W-1]}}, ir_q[OFF_W-1:0]};

   always_comb begin
      if (Branch) target = pc_q + br_off;
      else        target = {pc_q[DATA_W-1:JTGT_W], ir_q[JTGT_W-1:0]};
   end

   always_comb begin
      NextPC = target;
      unique case (PCSrc)
         PCSRC_ALU: NextPC = ALUOut;
         PCSRC_INC: NextPC = pc_q + {{(DATA_W - 1){1'b0}}, 1'b1};
         PCSRC_REG: NextPC = RegA;
         PCSRC_TGT: NextPC = target;
      endcase
   end

   fetch_pc_unit_branch_resolver u_branch_resolver (
      .CLK            (CLK),
      .RST            (RST),
      .branch_i       (Branch),
      .zero_i         (Zero),
      .take_branch_o  (take_branch),
      .branch_taken_o (BranchTaken)
   );

   // A taken branch always loads target regardless of PCSrc; any other
   // Branch cycle freezes the PC even if PCWrite is asserted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q <= RESET_PC;
      end else if (take_branch) begin
         pc_q <= target;
      end else if (!Branch && PCWrite) begin
         pc_q <= NextPC;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)          ir_q <= '0;
      else if (IRWrite) ir_q <= MemData;
   end

   assign PC       = pc_q;
   assign IR       = ir_q;
   assign Opcode   = ir_q[OPC_MSB:OPC_LSB];
   assign LinkAddr = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

   logic        CLK = 1'b0;
   logic        RST, PCWrite, Branch, IRWrite, Zero;
   logic [1:0]  PCSrc;
   logic [15:0] MemData, ALUOut, RegA;
   logic [15:0] PC, IR, LinkAddr, NextPC;
   logic [3:0]  Opcode;
   logic        BranchTaken;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [15:0] m_pc, m_ir;
   logic        m_bt;
   bit          m_valid = 0;
   bit          pend[$];  // captured zero flag of a half-finished BEQ

   always #5 CLK = ~CLK;

   fetch_pc_unit dut (
      .CLK         (CLK),
      .RST         (RST),
      .PCSrc       (PCSrc),
      .PCWrite     (PCWrite),
      .Branch      (Branch),
      .IRWrite     (IRWrite),
      .MemData     (MemData),
      .ALUOut      (ALUOut),
      .RegA        (RegA),
      .Zero        (Zero),
      .PC          (PC),
      .IR          (IR),
      .Opcode      (Opcode),
      .LinkAddr    (LinkAddr),
      .BranchTaken (BranchTaken),
      .NextPC      (NextPC)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_target(input logic br);
      logic [15:0] off;
      off = {{8{m_ir[7]}}, m_ir[7:0]};
      if (br) return m_pc + off;
      return {m_pc[15:12], m_ir[11:0]};
   endfunction

   function automatic logic [15:0] m_next();
      case (PCSrc)
         2'b00:   return ALUOut;
         2'b01:   return m_pc + 16'd1;
         2'b10:   return RegA;
         default: return m_target(Branch);
      endcase
   endfunction

   // Apply inputs mid-cycle and check combinational outputs
   task automatic drive(input logic rst, input logic [1:0] src, input logic pcw,
                        input logic br, input logic irw, input logic [15:0] md,
                        input logic [15:0] alu, input logic [15:0] ra, input logic z);
      RST = rst; PCSrc = src; PCWrite = pcw; Branch = br; IRWrite = irw;
      MemData = md; ALUOut = alu; RegA = ra; Zero = z;
      #1;
      if (m_valid) begin
         check("nextpc", NextPC, m_next());
         check("linkaddr", LinkAddr, m_pc);
         check("opcode", {12'h0, Opcode}, {12'h0, m_ir[15:12]});
      end
   endtask

   // Clock edge: advance the model, then check registered outputs
   task automatic tick();
      logic [15:0] nxt, tgt;
      bit z;
      nxt = m_next();
      tgt = m_target(1'b1);
      @(posedge CLK);
      if (RST) begin
         m_pc = 16'h0000; m_ir = 16'h0000; m_bt = 0; pend.delete(); m_valid = 1;
      end else begin
         m_bt = 0;
         if (Branch) begin
            if (pend.size() == 0) pend.push_back(Zero);
            else begin
               z = pend.pop_front();
               if (z) begin m_pc = tgt; m_bt = 1; end
            end
         end else begin
            pend.delete();
            if (PCWrite) m_pc = nxt;
         end
         if (IRWrite) m_ir = MemData;
      end
      #1;
      check("pc", PC, m_pc);
      check("ir", IR, m_ir);
      check("branchtaken", {15'h0, BranchTaken}, {15'h0, m_bt});
   endtask

   task automatic cyc(input logic rst, input logic [1:0] src, input logic pcw,
                      input logic br, input logic irw, input logic [15:0] md,
                      input logic [15:0] ra, input logic z);
      drive(rst, src, pcw, br, irw, md, 16'h5555, ra, z);
      tick();
   endtask

   // Load PC from RegA and optionally IR in the same cycle
   task automatic setup(input logic [15:0] pc, input logic irw, input logic [15:0] ir);
      cyc(0, 2'b10, 1, 0, irw, ir, pc, 0);
   endtask

   initial begin
      // Reset wins over PCWrite
      cyc(1, 2'b01, 1, 0, 1, 16'hDEAD, 16'h0, 0);
      check("rst_pc", PC, 16'h0000);
      check("rst_ir", IR, 16'h0000);
      check("rst_bt", {15'h0, BranchTaken}, 16'h0000);

      // Fetch / decode
      setup(16'h0010, 0, 16'h0);
      cyc(0, 2'b00, 0, 0, 1, 16'h3ABC, 16'h0, 0);
      check("ir_load", IR, 16'h3ABC);
      check("opcode3", {12'h0, Opcode}, 16'h0003);
      cyc(0, 2'b01, 1, 0, 0, 16'h0, 16'h0, 0);
      check("pc_inc", PC, 16'h0011);
      cyc(0, 2'b11, 1, 0, 0, 16'h0, 16'h0, 0);
      check("pc_jump", PC, 16'h0ABC);

      // Wrap
      setup(16'hFFFF, 0, 16'h0);
      cyc(0, 2'b01, 1, 0, 0, 16'h0, 16'h0, 0);
      check("pc_wrap", PC, 16'h0000);

      // BEQ taken (PCWrite asserted but must be ignored)
      setup(16'h0020, 1, 16'h40FE);
      cyc(0, 2'b01, 1, 1, 0, 16'h0, 16'h0, 1);
      check("beq_hold", PC, 16'h0020);
      cyc(0, 2'b01, 1, 1, 0, 16'h0, 16'h0, 0);
      check("beq_taken_pc", PC, 16'h001E);
      check("beq_taken_bt", {15'h0, BranchTaken}, 16'h0001);
      cyc(0, 2'b00, 0, 0, 0, 16'h0, 16'h0, 0);
      check("beq_pulse_end", {15'h0, BranchTaken}, 16'h0000);

      // BEQ not taken
      setup(16'h0020, 0, 16'h0);
      cyc(0, 2'b11, 0, 1, 0, 16'h0, 16'h0, 0);
      cyc(0, 2'b11, 0, 1, 0, 16'h0, 16'h0, 1);
      check("beq_nt_pc", PC, 16'h0020);
      check("beq_nt_bt", {15'h0, BranchTaken}, 16'h0000);

      // JAL
      setup(16'h1005, 1, 16'hC123);
      drive(0, 2'b11, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0);
      check("jal_link", LinkAddr, 16'h1005);
      tick();
      check("jal_pc", PC, 16'h1123);

      // Reset in EVAL, then a fresh branch pair restarts at IDLE
      setup(16'h0040, 1, 16'h0005);
      cyc(0, 2'b00, 0, 1, 0, 16'h0, 16'h0, 1);
      cyc(1, 2'b00, 0, 1, 0, 16'h0, 16'h0, 1);
      check("rst_mid_pc", PC, 16'h0000);
      check("rst_mid_bt", {15'h0, BranchTaken}, 16'h0000);
      cyc(0, 2'b00, 0, 1, 0, 16'h0, 16'h0, 1);
      check("restart_hold", PC, 16'h0000);
      cyc(0, 2'b00, 0, 1, 0, 16'h0, 16'h0, 0);
      check("restart_taken", PC, 16'h0000);
      check("restart_bt", {15'h0, BranchTaken}, 16'h0001);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
               1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
               16'($urandom), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
